divider: RTL and testbench
==========================

# divider

Sequential 8-bit radix-2 restoring divider for the arithmetic unit. It is the inverse partner of the multiply path: it takes a dividend and divisor, runs one shift-subtract step per clock, and returns quotient, remainder and a divide-by-zero flag. A start/done handshake connects it to the ALU control sequencer. Each trial subtraction is done with an internal 9-bit subtract, the carry-lookahead adder form with the divisor inverted and carry-in = 1.

## Interface
- No parameters; width fixed at 8 bits.
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request a division; sampled only when busy = 0
- signed_op  input  1  1 = two's-complement operands (honoured only with DIVIDER_SIGNED_EN)
- dividend  input  8  dividend, sampled on the accepting edge
- divisor  input  8  divisor, sampled on the accepting edge
- quotient  output  8  result quotient; held until the next completion
- remainder  output  8  result remainder; held until the next completion
- div_zero  output  1  divisor was zero for the last completed operation
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse: results valid

## Operation
- States: IDLE, CALC, FIX.
- IDLE: on an edge with start = 1:
  - Latch the operands, converted to magnitudes if the signed path is enabled and signed_op = 1.
  - Record the sign of the dividend and the sign of the quotient.
  - Clear the partial remainder.
  - Set count = 0.
  - Go to CALC, or to FIX with a zero flag if divisor == 0.
- CALC, once per cycle:
  - Shift {partial remainder, dividend register} left by one.
  - Compute trial = partial remainder − divisor, 9-bit.
  - If there is no borrow, keep the trial and set quotient bit = 1; otherwise restore and set quotient bit = 0.
  - count increments; after the 8th step (count == 7) go to FIX.
- FIX:
  - Apply sign correction: quotient negated if the operand signs differ; remainder takes the dividend's sign.
  - Drive quotient, remainder and div_zero; pulse done; go to IDLE.
- Divide by zero: quotient = 8'hFF, remainder = raw dividend, div_zero = 1. No iterations are run.
- Signed rules:
  - Quotient truncates toward zero.
  - −128 / −1 wraps to quotient 8'h80, remainder 0. No flag is raised.
- start while busy = 1 is ignored. Operand changes while busy are ignored.
- Reset (rst_n = 0 at any edge, including mid-operation):
  - State = IDLE; the in-flight operation is discarded with no done pulse.
  - quotient = 0, remainder = 0, div_zero = 0, busy = 0, done = 0.

## Timing
- Accepting edge E0; busy = 1 from after E0 through the cycle before done.
- Normal latency: CALC on edges E1..E8, FIX on E9. done = 1 and results update in the cycle after E9, with busy = 0 in that same cycle.
- Divide-by-zero latency: FIX on E1; done = 1 in the cycle after E1.
- Back-to-back: a start present in the done cycle is accepted (state is IDLE), giving one result every 10 cycles.
- div_zero updates only on completion and is held with the results.
- done is never high for two consecutive cycles.

## Configuration
- DIVIDER_SIGNED_EN
  - Defined: signed_op = 1 selects signed division.
    - The magnitude conversion is done at acceptance.
    - Sign correction is done in FIX.
    - The −128 / −1 wrap rule applies.
  - Undefined:
    - signed_op is ignored and all operands are treated as unsigned.
    - No sign logic is synthesised.
    - Latency is identical in both builds.

## Test plan
- Unsigned 100 / 7, start for one cycle: done exactly 10 cycles after the start edge (in the cycle after E9); quotient = 14, remainder = 2, div_zero = 0; busy high for 9 cycles.
- Unsigned 255 / 1, then back-to-back 255 / 16 with start held in the done cycle: results 255 r 0, then 15 r 15; second done 10 cycles after the first.
- 42 / 0: done in the cycle after E1; quotient = 8'hFF, remainder = 42, div_zero = 1; the next valid op clears div_zero.
- DIVIDER_SIGNED_EN build:
  - −100 / 7 gives quotient 8'hF2, remainder 8'hFE.
  - 100 / −7 gives 8'hF2, 8'h02.
  - −128 / −1 gives 8'h80, 8'h00.
  - Same stimulus without the macro: 156 / 7 gives 22 r 2.
- Start 200 / 3, pulse start again at E3 with 9 / 9: the second start is ignored, result 66 r 2.
- Start 200 / 3, assert rst_n = 0 at E4: all outputs 0 next cycle, no done; a following 9 / 9 completes normally as 1 r 0.

Source files
------------

// File: rtl/divider.sv
// -----------------------------------------------------------------------------
// divider -- sequential 8-bit radix-2 restoring divider
//
// Performs one shift-subtract step per clock. It returns the quotient, the
// remainder and a divide-by-zero flag through a start/done handshake.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   start      in   request a division (sampled only while busy = 0)
//   signed_op  in   1 = two's-complement operands (DIVIDER_SIGNED_EN builds)
//   dividend   in   [7:0] dividend, captured on the accepting edge
//   divisor    in   [7:0] divisor, captured on the accepting edge
//   quotient   out  [7:0] result quotient, held until the next completion
//   remainder  out  [7:0] result remainder, held until the next completion
//   div_zero   out  divisor was zero for the last completed operation
//   busy       out  operation in progress
//   done       out  one-cycle pulse, results valid
//
// Build option:
//   DIVIDER_SIGNED_EN  when defined, signed_op = 1 selects signed division.
//                      The magnitudes are formed at acceptance and the signs
//                      are corrected in FIX. When undefined, signed_op is
//                      ignored and no sign logic exists. Latency is the same
//                      in both builds.
// -----------------------------------------------------------------------------
module divider (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       signed_op,
    input  logic [7:0] dividend,
    input  logic [7:0] divisor,
    output logic [7:0] quotient,
    output logic [7:0] remainder,
    output logic       div_zero,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  rem_q, rem_d;        // partial remainder
    logic [7:0]  dvd_q, dvd_d;        // dividend shifting out, quotient shifting in
    logic [7:0]  dsr_q, dsr_d;        // divisor magnitude
    logic        zero_q, zero_d;      // current operation is a divide by zero
    logic [7:0]  quotient_q, quotient_d;
    logic [7:0]  remainder_q, remainder_d;
    logic        div_zero_q, div_zero_d;
    logic        done_q, done_d;

    logic        divisor_is_zero;
    logic [7:0]  dvd_mag;             // dividend as loaded into the datapath
    logic [7:0]  dsr_mag;
    logic [7:0]  fix_quot;            // sign-corrected final values
    logic [7:0]  fix_rem;

    assign divisor_is_zero = (divisor == 8'd0);

    // -------------------------------------------------------------------------
    // Sign handling
    // -------------------------------------------------------------------------
`ifdef DIVIDER_SIGNED_EN
    logic dvd_neg_q, dvd_neg_d;       // dividend was negative: the remainder takes its sign
    logic q_neg_q, q_neg_d;           // operand signs differ: negate the quotient
    logic dvd_neg_in;
    logic dsr_neg_in;

    always_comb begin
        dvd_neg_in = signed_op & dividend[7];
        dsr_neg_in = signed_op & divisor[7];
        // -128 has magnitude 128, which still fits as an unsigned 8-bit value.
        dvd_mag    = dvd_neg_in ? (8'd0 - dividend) : dividend;
        dsr_mag    = dsr_neg_in ? (8'd0 - divisor)  : divisor;
        dvd_neg_d  = dvd_neg_q;
        q_neg_d    = q_neg_q;
        if (state_q == IDLE && start) begin
            dvd_neg_d = dvd_neg_in;
            q_neg_d   = dvd_neg_in ^ dsr_neg_in;
        end
        // -128 / -1 gives magnitude 128 = 8'h80 and no negation, so it wraps.
        fix_quot = q_neg_q   ? (8'd0 - dvd_q) : dvd_q;
        fix_rem  = dvd_neg_q ? (8'd0 - rem_q) : rem_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dvd_neg_q <= 1'b0;
            q_neg_q   <= 1'b0;
        end else begin
            dvd_neg_q <= dvd_neg_d;
            q_neg_q   <= q_neg_d;
        end
    end
`else
    logic unused_signed_op;
    assign unused_signed_op = signed_op;

    always_comb begin
        dvd_mag  = dividend;
        dsr_mag  = divisor;
        fix_quot = dvd_q;
        fix_rem  = rem_q;
    end
`endif

    // -------------------------------------------------------------------------
    // Trial subtraction: {rem, next dividend bit} - divisor over 9 bits. It is
    // done as an add of the inverted divisor with carry-in 1. A carry out
    // means no borrow, so the trial result is kept.
    // -------------------------------------------------------------------------
    logic [8:0] shifted;
    logic [9:0] sub_sum;
    logic       no_borrow;
    logic       unused_sub_bit;

    assign shifted        = {rem_q, dvd_q[7]};
    assign sub_sum        = {1'b0, shifted} + {1'b0, ~{1'b0, dsr_q}} + 10'd1;
    assign no_borrow      = sub_sum[9];
    // The partial remainder always stays below the divisor, so bit 8 of a kept
    // trial result is zero.
    assign unused_sub_bit = sub_sum[8];

    // -------------------------------------------------------------------------
    // FSM: state register / next-state / outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = divisor_is_zero ? FIX : CALC;
            CALC:    if (cnt_q == 3'd7) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != IDLE);
        done      = done_q;
        quotient  = quotient_q;
        remainder = remainder_q;
        div_zero  = div_zero_q;
    end

    // -------------------------------------------------------------------------
    // Datapath next-state
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a hold value before the case, so paths that do
        // not assign it keep the current value and no latch is inferred.
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        dvd_d       = dvd_q;
        dsr_d       = dsr_q;
        zero_d      = zero_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    rem_d  = 8'd0;
                    cnt_d  = 3'd0;
                    dsr_d  = dsr_mag;
                    zero_d = divisor_is_zero;
                    // A divide by zero reports the raw dividend, so it skips
                    // the magnitude conversion.
                    dvd_d  = divisor_is_zero ? dividend : dvd_mag;
                end
            end
            CALC: begin
                rem_d = no_borrow ? sub_sum[7:0] : shifted[7:0];
                dvd_d = {dvd_q[6:0], no_borrow};
                cnt_d = cnt_q + 3'd1;
            end
            FIX: begin
                done_d     = 1'b1;
                div_zero_d = zero_q;
                if (zero_q) begin
                    quotient_d  = 8'hFF;
                    remainder_d = dvd_q;
                end else begin
                    quotient_d  = fix_quot;
                    remainder_d = fix_rem;
                end
            end
            default: ;
        endcase
    end

    // NOTE: state flops use non-blocking assignments. All flops then sample
    // their _d values from the same edge, whatever order the statements are in.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            rem_q       <= 8'd0;
            dvd_q       <= 8'd0;
            dsr_q       <= 8'd0;
            zero_q      <= 1'b0;
            quotient_q  <= 8'd0;
            remainder_q <= 8'd0;
            div_zero_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            dvd_q       <= dvd_d;
            dsr_q       <= dsr_d;
            zero_q      <= zero_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_divider.sv
// -----------------------------------------------------------------------------
// tb_divider -- self-checking bench for divider
//
// Expected results come from plain integer division in the model function.
// Each scenario task drives the stimulus and compares the results inline.
// -----------------------------------------------------------------------------
module tb_divider;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       signed_op;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_zero;
    logic       busy;
    logic       done;

    int pass_cnt  = 0;
    int total_cnt = 0;

`ifdef DIVIDER_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
    } res_t;

    always #5 clk = ~clk;

    divider dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .signed_op (signed_op),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .busy      (busy),
        .done      (done)
    );

    // Reference: integer division. Signed division truncates toward zero and
    // the remainder follows the dividend's sign. -128/-1 = 128, which
    // truncates to 8'h80.
    function automatic res_t model(input logic [7:0] a, input logic [7:0] b, input logic s);
        res_t m;
        int   sa;
        int   sb;
        if (b == 8'd0) begin
            m.q = 8'hFF;
            m.r = a;
            m.z = 1'b1;
        end else if (s && SIGNED_EN) begin
            sa  = int'($signed(a));
            sb  = int'($signed(b));
            m.q = 8'(sa / sb);
            m.r = 8'(sa % sb);
            m.z = 1'b0;
        end else begin
            m.q = a / b;
            m.r = a % b;
            m.z = 1'b0;
        end
        return m;
    endfunction

    // Issues one operation and waits for done, with a bound on the wait.
    // lat is the number of clock edges after the accepting edge until done is
    // seen. busy_n is the number of sampled cycles with busy high.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                         output int lat, output int busy_n);
        @(posedge clk); #1;
        dividend  = a;
        divisor   = b;
        signed_op = s;
        start     = 1'b1;
        @(posedge clk); #1;                       // accepting edge E0
        start     = 1'b0;
        dividend  = 8'($urandom);                 // must be ignored while busy
        divisor   = 8'($urandom);
        lat       = 0;
        busy_n    = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) busy_n++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        signed_op = 1'b0;
        dividend = 8'd0;
        divisor = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if ({quotient, remainder, div_zero, busy, done} !== 19'd0)
            $display("FAIL reset_outputs: got q=%h r=%h z=%b busy=%b done=%b, want all 0",
                     quotient, remainder, div_zero, busy, done);
        else pass_cnt++;
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int lat, bn;
        do_op(8'd100, 8'd7, 1'b0, lat, bn);
        total_cnt++;
        if (lat !== 9) $display("FAIL basic_latency: got %0d edges, want 9", lat);
        else pass_cnt++;
        total_cnt++;
        if (bn !== 9) $display("FAIL basic_busy_cycles: got %0d, want 9", bn);
        else pass_cnt++;
        total_cnt++;
        if ({quotient, remainder, div_zero} !== {8'd14, 8'd2, 1'b0})
            $display("FAIL basic_100_7: got q=%0d r=%0d z=%b, want 14 r 2 z 0",
                     quotient, remainder, div_zero);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL basic_busy_in_done: got %b, want 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int n;
        @(posedge clk); #1;
        dividend = 8'd255; divisor = 8'd1; signed_op = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        total_cnt++;
        if ({quotient, remainder} !== {8'd255, 8'd0})
            $display("FAIL b2b_255_1: got q=%0d r=%0d, want 255 r 0", quotient, remainder);
        else pass_cnt++;
        // start is presented in the done cycle
        dividend = 8'd255; divisor = 8'd16; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        total_cnt++;
        if (done !== 1'b0) $display("FAIL b2b_done_twice: got done=%b, want 0", done);
        else pass_cnt++;
        while (done !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        total_cnt++;
        if (n !== 10) $display("FAIL b2b_spacing: got %0d cycles between dones, want 10", n);
        else pass_cnt++;
        total_cnt++;
        if ({quotient, remainder} !== {8'd15, 8'd15})
            $display("FAIL b2b_255_16: got q=%0d r=%0d, want 15 r 15", quotient, remainder);
        else pass_cnt++;
    endtask

    task automatic test_div_zero;
        int lat, bn;
        do_op(8'd42, 8'd0, 1'b0, lat, bn);
        total_cnt++;
        if (lat !== 1) $display("FAIL dz_latency: got %0d edges, want 1", lat);
        else pass_cnt++;
        total_cnt++;
        if ({quotient, remainder, div_zero} !== {8'hFF, 8'd42, 1'b1})
            $display("FAIL dz_result: got q=%h r=%0d z=%b, want ff r 42 z 1",
                     quotient, remainder, div_zero);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (div_zero !== 1'b1) $display("FAIL dz_held: got z=%b, want 1", div_zero);
        else pass_cnt++;
        do_op(8'd50, 8'd5, 1'b0, lat, bn);
        total_cnt++;
        if ({quotient, remainder, div_zero} !== {8'd10, 8'd0, 1'b0})
            $display("FAIL dz_cleared: got q=%0d r=%0d z=%b, want 10 r 0 z 0",
                     quotient, remainder, div_zero);
        else pass_cnt++;
    endtask

    task automatic test_signed;
        int lat, bn;
        logic [7:0] eq [3];
        logic [7:0] er [3];
        logic [7:0] ta [3];
        logic [7:0] tb [3];
        ta[0] = 8'h9C; tb[0] = 8'd7;     // -100 / 7  (156 / 7 unsigned)
        ta[1] = 8'd100; tb[1] = 8'hF9;   // 100 / -7  (100 / 249 unsigned)
        ta[2] = 8'h80; tb[2] = 8'hFF;    // -128 / -1 (128 / 255 unsigned)
        if (SIGNED_EN) begin
            eq[0] = 8'hF2; er[0] = 8'hFE;
            eq[1] = 8'hF2; er[1] = 8'h02;
            eq[2] = 8'h80; er[2] = 8'h00;
        end else begin
            eq[0] = 8'd22; er[0] = 8'd2;
            eq[1] = 8'd0;  er[1] = 8'd100;
            eq[2] = 8'd0;  er[2] = 8'd128;
        end
        for (int i = 0; i < 3; i++) begin
            do_op(ta[i], tb[i], 1'b1, lat, bn);
            total_cnt++;
            if ({quotient, remainder, div_zero, lat} !== {eq[i], er[i], 1'b0, 32'd9})
                $display("FAIL signed_%0d: got q=%h r=%h z=%b lat=%0d, want q=%h r=%h z=0 lat=9",
                         i, quotient, remainder, div_zero, lat, eq[i], er[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_start_ignored;
        int n;
        @(posedge clk); #1;
        dividend = 8'd200; divisor = 8'd3; signed_op = 1'b0; start = 1'b1;
        @(posedge clk); #1;                       // E0
        start = 1'b0;
        @(posedge clk); #1;                       // E1
        @(posedge clk); #1;                       // E2
        dividend = 8'd9; divisor = 8'd9; start = 1'b1;
        @(posedge clk); #1;                       // E3
        start = 1'b0;
        n = 3;
        while (done !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        total_cnt++;
        if ({quotient, remainder, n} !== {8'd66, 8'd2, 32'd9})
            $display("FAIL ignore_start: got q=%0d r=%0d lat=%0d, want 66 r 2 lat 9",
                     quotient, remainder, n);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if ({done, busy} !== 2'b00)
            $display("FAIL ignore_no_second_op: got done=%b busy=%b, want 0 0", done, busy);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_op;
        int lat, bn, done_seen;
        @(posedge clk); #1;
        dividend = 8'd200; divisor = 8'd3; signed_op = 1'b0; start = 1'b1;
        @(posedge clk); #1;                       // E0
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end  // E1..E3
        rst_n = 1'b0;
        @(posedge clk); #1;                       // E4 applies reset
        total_cnt++;
        if ({quotient, remainder, div_zero, busy, done} !== 19'd0)
            $display("FAIL midreset_outputs: got q=%h r=%h z=%b busy=%b done=%b, want all 0",
                     quotient, remainder, div_zero, busy, done);
        else pass_cnt++;
        rst_n = 1'b1;
        done_seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done === 1'b1) done_seen++;
        end
        total_cnt++;
        if (done_seen !== 0) $display("FAIL midreset_no_done: got %0d done pulses, want 0", done_seen);
        else pass_cnt++;
        do_op(8'd9, 8'd9, 1'b0, lat, bn);
        total_cnt++;
        if ({quotient, remainder, div_zero, lat} !== {8'd1, 8'd0, 1'b0, 32'd9})
            $display("FAIL midreset_recover: got q=%0d r=%0d z=%b lat=%0d, want 1 r 0 z 0 lat 9",
                     quotient, remainder, div_zero, lat);
        else pass_cnt++;
    endtask

    task automatic test_random;
        int   lat, bn;
        res_t exp_r;
        logic [7:0] a, b;
        logic s;
        for (int i = 0; i < 60; i++) begin
            a = 8'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            if (i < 4) b = 8'd1 << i;             // small power-of-two divisors
            s = 1'($urandom);
            exp_r = model(a, b, s);
            do_op(a, b, s, lat, bn);
            total_cnt++;
            if ({quotient, remainder, div_zero} !== exp_r ||
                lat !== ((b == 8'd0) ? 1 : 9))
                $display("FAIL random_%0d: %h/%h s=%b got q=%h r=%h z=%b lat=%0d, want q=%h r=%h z=%b",
                         i, a, b, s, quotient, remainder, div_zero, lat,
                         exp_r.q, exp_r.r, exp_r.z);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_div_zero();
        test_signed();
        test_start_ignored();
        test_reset_mid_op();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
